// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencer.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
//
// Contents: arithmetic_t op encoding, seq_state_t FSM states, LED patterns,
// and pick_op(), which resolves simultaneous op-key presses (lowest index wins).
package calc_pkg;

    typedef enum logic [1:0] {
        PLUS           = 2'd0,
        SUBSTRACTION   = 2'd1,
        MULTIPLICATION = 2'd2,
        DEVISION       = 2'd3
    } arithmetic_t;

    typedef enum logic [1:0] {
        ENTRY  = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } seq_state_t;

    // Status LEDs are active-low.
    localparam logic [2:0] LED_IDLE = 3'b110;
    localparam logic [2:0] LED_A    = 3'b101;
    localparam logic [2:0] LED_B    = 3'b011;

    // press[0]=PLUS ... press[3]=DEVISION; lowest set bit wins.
    function automatic arithmetic_t pick_op(input logic [3:0] press);
        if (press[0]) return PLUS;
        if (press[1]) return SUBSTRACTION;
        if (press[2]) return MULTIPLICATION;
        return DEVISION;
    endfunction

endpackage

// File: rtl/calc_button_debouncer.sv
// Synchroniser + optional debouncer + press-edge detector for one active-low key.
// Latency: 2 sync + DEBOUNCE_CYCLES + 1 cycles to press (3 cycles when debounce is compiled out).
// Backpressure: none; press is a one-cycle pulse and is lost if the consumer ignores it.
//
// Ports: clk, rst (sync, active-high), pin (raw active-low key),
//        level (conditioned key level, high = released), press (one-cycle pulse on high->low).
// Macro CALC_SEQ_DEBOUNCE_EN: when defined the synced level must be stable for
// DEBOUNCE_CYCLES cycles before it is accepted; otherwise the synced level is used directly.
module calc_button_debouncer
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 5000
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic sync_1;
    logic sync_2;
    logic lvl;
    logic lvl_q;

    // Reset to "released" so a key held through reset is seen as a fresh press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= pin;
            sync_2 <= sync_1;
        end
    end

`ifdef CALC_SEQ_DEBOUNCE_EN
    logic [CNT_W-1:0] cnt;
    logic             db;

    // Count consecutive cycles the synced level disagrees with the accepted
    // level; any return to agreement restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            db  <= 1'b1;
        end else if (sync_2 != db) begin
            if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db  <= sync_2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    assign lvl = db;
`else
    logic [CNT_W-1:0] cnt_unused;
    assign cnt_unused = '0;
    assign lvl        = sync_2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q <= 1'b1;
            press <= 1'b0;
        end else begin
            lvl_q <= lvl;
            press <= lvl_q & ~lvl;
        end
    end

    assign level = lvl_q;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: latches operands, launches one ALU op, selects the display.
// Latency: key press acts 1 cycle after its pulse; alu_start the cycle after an op press.
// Backpressure: none; presses outside ENTRY are discarded, alu_done accepted only in WAIT.
//
// Ports: clk, rst (sync, active-high); in_number/key/arif active-low front panel;
//        alu_op/alu_a/alu_b/alu_start -> arithmetic unit, alu_done/alu_result/alu_err <- it;
//        disp_value/disp_point/disp_error -> 7-seg driver; led active-low status.
// Macro CALC_SEQ_DEBOUNCE_EN enables key debouncing (see calc_button_debouncer).
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int IN_WIDTH        = 4,
    parameter int RES_WIDTH       = 12,
    parameter int DEBOUNCE_CYCLES = 5000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [IN_WIDTH-1:0]         in_number,
    input  logic [1:0]                  key,
    input  logic [3:0]                  arif,
    output logic [1:0]                  alu_op,
    output logic [IN_WIDTH-1:0]         alu_a,
    output logic [IN_WIDTH-1:0]         alu_b,
    output logic                        alu_start,
    input  logic                        alu_done,
    input  logic signed [RES_WIDTH-1:0] alu_result,
    input  logic                        alu_err,
    output logic signed [RES_WIDTH-1:0] disp_value,
    output logic                        disp_point,
    output logic                        disp_error,
    output logic [2:0]                  led
);

    seq_state_t state;

    logic [IN_WIDTH-1:0]  num_s1;
    logic [IN_WIDTH-1:0]  num_s2;
    logic [IN_WIDTH-1:0]  operand;
    logic [RES_WIDTH-1:0] operand_ext;

    logic [5:0] pins;
    logic [5:0] btn_level;
    logic [5:0] btn_press;
    logic [1:0] key_press;
    logic [3:0] arif_press;
    logic       arif_released;
    logic [1:0] key_level_unused;

    // Operand switches are level inputs: synchronised only, not debounced.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_s1 <= '1;
            num_s2 <= '1;
        end else begin
            num_s1 <= in_number;
            num_s2 <= num_s1;
        end
    end

    assign operand     = ~num_s2;
    assign operand_ext = {{(RES_WIDTH-IN_WIDTH){1'b0}}, operand};

    assign pins = {arif, key};

    for (genvar i = 0; i < 6; i++) begin : g_btn
        calc_button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk  (clk),
            .rst  (rst),
            .pin  (pins[i]),
            .level(btn_level[i]),
            .press(btn_press[i])
        );
    end

    assign key_press        = btn_press[1:0];
    assign arif_press       = btn_press[5:2];
    assign arif_released    = &btn_level[5:2];
    assign key_level_unused = btn_level[1:0];

    // disp_value doubles as the result register: it holds alu_result from
    // the WAIT->RESULT transition until the op keys are released.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ENTRY;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= PLUS;
            alu_start  <= 1'b0;
            disp_value <= '0;
            disp_point <= 1'b0;
            disp_error <= 1'b0;
            led        <= LED_IDLE;
        end else begin
            alu_start <= 1'b0;
            case (state)
                ENTRY: begin
                    disp_value <= operand_ext;
                    if (|arif_press) begin
                        // An op press takes priority; key presses in the same cycle are dropped.
                        alu_op    <= pick_op(arif_press);
                        alu_start <= 1'b1;
                        state     <= LAUNCH;
                    end else if (key_press[0]) begin
                        alu_a <= operand;
                        led   <= LED_A;
                    end else if (key_press[1]) begin
                        alu_b <= operand;
                        led   <= LED_B;
                    end
                end
                LAUNCH: begin
                    // alu_done here would precede the start being seen: ignore it.
                    state <= WAIT;
                end
                WAIT: begin
                    if (alu_done) begin
                        disp_value <= alu_result;
                        disp_error <= alu_err;
                        disp_point <= (alu_op == DEVISION) && !alu_err;
                        led        <= LED_IDLE;
                        state      <= RESULT;
                    end
                end
                RESULT: begin
                    if (arif_released) begin
                        disp_point <= 1'b0;
                        disp_error <= 1'b0;
                        disp_value <= operand_ext;
                        state      <= ENTRY;
                    end
                end
                default: state <= ENTRY;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed front-panel stimulus, arithmetic-unit model,
// scoreboard queue of expected launches/results checked by an independent monitor.
module tb_calc_sequencer;

    localparam int HOLD = 20;

    logic               clk = 1'b0;
    logic               rst;
    logic [3:0]         in_number;
    logic [1:0]         key;
    logic [3:0]         arif;
    logic [1:0]         alu_op;
    logic [3:0]         alu_a;
    logic [3:0]         alu_b;
    logic               alu_start;
    logic               alu_done   = 1'b0;
    logic signed [11:0] alu_result = '0;
    logic               alu_err    = 1'b0;
    logic signed [11:0] disp_value;
    logic               disp_point;
    logic               disp_error;
    logic [2:0]         led;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    calc_sequencer #(
        .IN_WIDTH(4),
        .RES_WIDTH(12),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_number (in_number),
        .key       (key),
        .arif      (arif),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_start (alu_start),
        .alu_done  (alu_done),
        .alu_result(alu_result),
        .alu_err   (alu_err),
        .disp_value(disp_value),
        .disp_point(disp_point),
        .disp_error(disp_error),
        .led       (led)
    );

    // Arithmetic-unit model: done pulse 3 cycles after start; not reset, so a
    // done from an aborted op still arrives.
    function automatic logic [12:0] model_calc(input logic [1:0] op, input logic [3:0] a,
                                               input logic [3:0] b);
        int   r;
        logic e;
        e = 1'b0;
        case (op)
            2'd0:    r = int'(a) + int'(b);
            2'd1:    r = int'(a) - int'(b);
            2'd2:    r = int'(a) * int'(b);
            default: begin
                if (b == 4'd0) begin
                    e = 1'b1;
                    r = 0;
                end else begin
                    r = (100 * int'(a)) / int'(b);
                end
            end
        endcase
        return {e, r[11:0]};
    endfunction

    logic [1:0] m_op;
    logic [3:0] m_a;
    logic [3:0] m_b;
    int         m_dly = 0;

    always @(posedge clk) begin
        alu_done <= 1'b0;
        if (alu_start) begin
            m_op  <= alu_op;
            m_a   <= alu_a;
            m_b   <= alu_b;
            m_dly <= 3;
        end else if (m_dly != 0) begin
            m_dly <= m_dly - 1;
            if (m_dly == 1) begin
                alu_done               <= 1'b1;
                {alu_err, alu_result}  <= model_calc(m_op, m_a, m_b);
            end
        end
    end

    typedef struct {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        int         val;
        logic       pt;
        logic       er;
        logic       chk;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic wait_done = 1'b0;
    logic res_due   = 1'b0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every launch pops one expectation; the result is checked the
    // cycle after the model's done pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (res_due) begin
                res_due = 1'b0;
                check("res_value", $signed(disp_value), cur.val);
                check("res_point", disp_point, cur.pt);
                check("res_error", disp_error, cur.er);
                check("res_led", led, 3'b110);
            end
            if (alu_start === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_start: got alu_start=1 expected none at %0t", $time);
                end else begin
                    cur = exp_q.pop_front();
                    check("start_op", alu_op, cur.op);
                    check("start_a", alu_a, cur.a);
                    check("start_b", alu_b, cur.b);
                    wait_done = cur.chk;
                end
            end
            if (alu_done && wait_done) begin
                wait_done = 1'b0;
                res_due   = 1'b1;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic latch(input int idx, input logic [3:0] v);
        in_number = ~v;
        cyc(4);
        key[idx] = 1'b0;
        cyc(HOLD);
        key[idx] = 1'b1;
        cyc(HOLD);
    endtask

    task automatic expect_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                             input int val, input logic pt, input logic er, input logic chk);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.val = val; e.pt = pt; e.er = er; e.chk = chk;
        exp_q.push_back(e);
    endtask

    task automatic start_op(input logic [3:0] pat, input logic [1:0] op, input logic [3:0] a,
                            input logic [3:0] b, input int val, input logic pt, input logic er);
        expect_op(op, a, b, val, pt, er, 1'b1);
        arif = pat;
        cyc(30);
    endtask

    task automatic end_op();
        arif = 4'hF;
        cyc(HOLD);
    endtask

    initial begin
        logic found;
        rst       = 1'b1;
        in_number = ~4'd9;
        key       = 2'b11;
        arif      = 4'hF;
        cyc(3);
        check("rst_led", led, 3'b110);
        check("rst_disp", disp_value, 0);
        check("rst_start", alu_start, 0);
        check("rst_a", alu_a, 0);
        check("rst_b", alu_b, 0);
        check("rst_op", alu_op, 0);
        check("rst_point", disp_point, 0);
        check("rst_error", disp_error, 0);
        rst = 1'b0;
        cyc(6);
        check("entry_disp", disp_value, 9);
        check("entry_led", led, 3'b110);

        // Basic add with LED progression
        latch(0, 4'd7);
        check("latch_a_led", led, 3'b101);
        check("latch_a", alu_a, 7);
        latch(1, 4'd3);
        check("latch_b_led", led, 3'b011);
        check("latch_b", alu_b, 3);
        in_number = ~4'd12;
        start_op(4'b1110, 2'd0, 4'd7, 4'd3, 10, 1'b0, 1'b0);
        end_op();
        check("post_release_disp", disp_value, 12);
        check("post_release_point", disp_point, 0);

        // Subtraction (negative) and maximum multiplication
        latch(0, 4'd2);
        latch(1, 4'd5);
        start_op(4'b1101, 2'd1, 4'd2, 4'd5, -3, 1'b0, 1'b0);
        end_op();
        latch(0, 4'd15);
        latch(1, 4'd15);
        start_op(4'b1011, 2'd2, 4'd15, 4'd15, 225, 1'b0, 1'b0);
        end_op();

        // Division with decimal point, then divide by zero
        latch(0, 4'd7);
        latch(1, 4'd3);
        start_op(4'b0111, 2'd3, 4'd7, 4'd3, 233, 1'b1, 1'b0);
        end_op();
        check("div_point_cleared", disp_point, 0);
        latch(1, 4'd0);
        start_op(4'b0111, 2'd3, 4'd7, 4'd0, 0, 1'b0, 1'b1);
        check("err_held", disp_error, 1);
        end_op();
        check("err_cleared", disp_error, 0);

        // Simultaneous op keys: lowest index wins
        latch(1, 4'd4);
        start_op(4'b0101, 2'd1, 4'd7, 4'd4, 3, 1'b0, 1'b0);
        end_op();

        // Both operand keys together: A only
        in_number = ~4'd6;
        cyc(4);
        key = 2'b00;
        cyc(HOLD);
        key = 2'b11;
        cyc(HOLD);
        check("both_keys_a", alu_a, 6);
        check("both_keys_b", alu_b, 4);
        check("both_keys_led", led, 3'b101);

        // Key press landing while the op is in flight is dropped
        expect_op(2'd0, 4'd6, 4'd4, 10, 1'b0, 1'b0, 1'b1);
        arif = 4'b1110;
        cyc(2);
        in_number = ~4'd1;
        key[0] = 1'b0;
        cyc(28);
        key[0] = 1'b1;
        end_op();
        check("busy_press_a", alu_a, 6);
        check("busy_press_led", led, 3'b110);

`ifdef CALC_SEQ_DEBOUNCE_EN
        // Short glitches never reach the debounce threshold
        in_number = ~4'd11;
        cyc(4);
        repeat (3) begin
            key[0] = 1'b0;
            cyc(2);
            key[0] = 1'b1;
            cyc(4);
        end
        cyc(HOLD);
        check("glitch_a", alu_a, 6);
        check("glitch_led", led, 3'b110);
`endif

        // Reset while waiting for the arithmetic unit
        in_number = ~4'd5;
        expect_op(2'd2, 4'd6, 4'd4, 24, 1'b0, 1'b0, 1'b0);
        arif  = 4'b1011;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc(1);
            if (alu_start === 1'b1) found = 1'b1;
        end
        check("abort_start_seen", found, 1);
        cyc(1);
        rst  = 1'b1;
        arif = 4'hF;
        cyc(1);
        check("abort_led", led, 3'b110);
        check("abort_a", alu_a, 0);
        check("abort_b", alu_b, 0);
        check("abort_op", alu_op, 0);
        check("abort_disp", disp_value, 0);
        rst = 1'b0;
        cyc(HOLD);
        check("stale_done_led", led, 3'b110);
        check("stale_done_error", disp_error, 0);
        check("stale_done_disp", disp_value, 5);

        // Normal operation after the abort
        latch(0, 4'd2);
        latch(1, 4'd3);
        start_op(4'b1110, 2'd0, 4'd2, 4'd3, 5, 1'b0, 1'b0);
        end_op();

        check("queue_drained", exp_q.size(), 0);
        check("no_pending_result", {30'd0, wait_done, res_due}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
